// File: rtl/eth_tx_stream_source_if.sv
// Avalon-ST transmit bus between the frame source and the MAC ff_tx port.
// Ready latency is 0: a beat transfers in any cycle where valid and ready are both high.
interface eth_tx_stream_source_if;
    logic [31:0] data_out;
    logic        valid;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        error;
    logic        ready;

    modport master (
        output data_out, valid, sop, eop, empty, error,
        input  ready
    );

    modport slave (
        input  data_out, valid, sop, eop, empty, error,
        output ready
    );
endinterface

// File: rtl/eth_tx_stream_source.sv
// Plays a software-loaded Ethernet frame out as 32-bit Avalon-ST beats into the MAC ff_tx port.
// The frame buffer is written in IDLE only and is replayed on every legal start.
module eth_tx_stream_source #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned ADDRW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   load_clear,
    input  logic                   load_en,
    input  logic [31:0]            load_data,
    input  logic [10:0]            byte_len,
    input  logic                   start,
    eth_tx_stream_source_if.master st,
    output logic                   busy,
    output logic                   done,
    output logic                   len_err,
    output logic [15:0]            frames_sent
);
    localparam int unsigned PTRW      = ADDRW + 1;
    localparam int unsigned MAX_BYTES = DEPTH * 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       mem [DEPTH];
    logic [PTRW-1:0]   wr_ptr;
    logic [ADDRW-1:0]  rd_ptr;
    logic [ADDRW-1:0]  last_idx;
    logic [1:0]        last_empty;

    logic              len_ok_c;
    logic              start_ok_c;
    logic              start_bad_c;
    logic              wr_en_c;
    logic              eop_c;
    logic              xfer_c;
    logic [11:0]       nwords_c;

    // Start qualification; the top pointer bit marks a full buffer since the pointer saturates at DEPTH.
    assign len_ok_c    = (byte_len != 11'd0) && (32'(byte_len) <= MAX_BYTES);
    assign start_ok_c  = (state == IDLE) && start && len_ok_c;
    assign start_bad_c = (state == IDLE) && start && !len_ok_c;
    assign wr_en_c     = (state == IDLE) && !load_clear && load_en && !start_ok_c && !wr_ptr[PTRW-1];
    assign nwords_c    = (12'(byte_len) + 12'd3) >> 2;

    assign eop_c  = (rd_ptr == last_idx);
    assign xfer_c = (state == SEND) && st.ready;

    // Stream outputs decode directly from state and read pointer.
    assign st.valid    = (state == SEND);
    assign st.data_out = (state == SEND) ? mem[rd_ptr] : 32'd0;
    assign st.sop      = (state == SEND) && (rd_ptr == '0);
    assign st.eop      = (state == SEND) && eop_c;
    assign st.empty    = ((state == SEND) && eop_c) ? last_empty : 2'd0;
    assign st.error    = 1'b0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok_c) state_next = SEND;
            SEND:    if (xfer_c && eop_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pointers, latched frame geometry and status flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_idx    <= '0;
            last_empty  <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            len_err     <= 1'b0;
            frames_sent <= 16'd0;
        end else begin
            if (state == IDLE) begin
                if (load_clear) begin
                    wr_ptr <= '0;
                end else if (wr_en_c) begin
                    wr_ptr <= wr_ptr + PTRW'(1);
                end
            end

            if (start_ok_c) begin
                rd_ptr     <= '0;
                last_idx   <= ADDRW'(nwords_c - 12'd1);
                last_empty <= 2'(2'd0 - byte_len[1:0]);
                len_err    <= 1'b0;
            end else begin
                if (start_bad_c) begin
                    len_err <= 1'b1;
                end
                if (xfer_c && !eop_c) begin
                    rd_ptr <= rd_ptr + ADDRW'(1);
                end
            end

            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
            if (state_next == DONE) begin
                frames_sent <= frames_sent + 16'd1;
            end
        end
    end

    // Frame buffer has no reset so contents survive for retransmission.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr[ADDRW-1:0]] <= load_data;
        end
    end
endmodule

// File: doc/eth_tx_stream_source.md
# eth_tx_stream_source

Avalon-ST packet source that plays a stored Ethernet frame into the transmit FIFO interface (ff_tx) of the triple-speed MAC in the Qsys system. It is the transmit-side counterpart of the sniffer's receive-side packet consumer. Software or a test controller loads frame words into an internal buffer, then pulses `start`. The block emits the frame as 32-bit beats with sop/eop/empty under `ready` backpressure, so known traffic can be driven out of the PHY and looped back into the sniffer.

## Interface
Parameters:
- `DEPTH`, default 64: buffer depth in 32-bit words. Maximum frame is DEPTH*4 bytes. Must be a power of two, ≥ 2.
- `ADDRW`, default $clog2(DEPTH): buffer pointer width.

Ports:
- `clk` in 1: single clock for everything.
- `n_rst` in 1: asynchronous, active-low reset.
- `load_clear` in 1: resets the write pointer to 0.
- `load_en` in 1: writes `load_data` to buffer[wr_ptr].
- `load_data` in 32: frame word. Byte 0 of the frame is in [31:24].
- `byte_len` in 11: frame length in bytes. Sampled when `start` is accepted.
- `start` in 1: single-cycle request to transmit the buffer.
- `data_out` out 32: Avalon-ST data.
- `valid` out 1: Avalon-ST valid.
- `sop` out 1: Avalon-ST start of packet.
- `eop` out 1: Avalon-ST end of packet.
- `empty` out 2: number of unused bytes in the eop word.
- `error` out 1: tied 0.
- `ready` in 1: MAC ff_tx_rdy. Ready latency is 0.
- `busy` out 1: high in SEND and DONE.
- `done` out 1: one-cycle pulse after a frame completes.
- `len_err` out 1: sticky flag for an illegal start.
- `frames_sent` out 16: count of completed frames. Wraps.

## Operation
States: IDLE, SEND, DONE.

- **Loading (IDLE only):**
  - `load_en` writes buffer[wr_ptr], then wr_ptr increments.
  - Once wr_ptr reaches DEPTH, further writes are dropped. The pointer saturates and does not wrap.
  - `load_clear` has priority over `load_en` in the same cycle.
  - `load_en` and `load_clear` are ignored in SEND and DONE.
  - Buffer contents persist until overwritten, so pulsing `start` again retransmits the same frame.
- **IDLE → SEND:** on `start` with a legal length, 1 ≤ `byte_len` ≤ DEPTH*4.
  - Latch `nwords = (byte_len+3)>>2` and `last_empty = (4 - byte_len[1:0]) & 3`.
  - Set rd_ptr = 0 and clear `len_err`.
  - `load_en` in that same cycle is ignored.
- **Illegal start:** `start` in IDLE with `byte_len` = 0 or > DEPTH*4.
  - Stay in IDLE and set `len_err`. It stays set until the next legal start.
- **Start while busy:** `start` in SEND or DONE is ignored. `len_err` is unchanged.
- **SEND, beat rules:**
  - `valid` = 1 and `data_out` = buffer[rd_ptr].
  - `sop` = (rd_ptr == 0).
  - `eop` = (rd_ptr == nwords-1).
  - `empty` = `last_empty` when `eop` is high, else 0.
  - A one-word frame has `sop` and `eop` high on the same beat.
- **SEND, transfer:** a beat transfers when `valid` & `ready`.
  - If it is the eop beat, go to DONE. Otherwise rd_ptr increments.
  - While `ready` = 0, `data_out`/`sop`/`eop`/`empty` hold stable and `valid` stays 1. A started frame is never dropped or aborted.
- **SEND, stale words:** words beyond wr_ptr are sent as whatever the buffer holds. No check is made against wr_ptr.
- **DONE:** lasts one cycle.
  - `done` = 1 and `frames_sent` increments, wrapping 0xFFFF → 0.
  - Next state is IDLE.

## Timing
- **Reset values:**
  - Outputs: `valid`, `sop`, `eop`, `empty`, `error`, `busy`, `done`, `len_err` = 0; `frames_sent` = 0; `data_out` = 0.
  - Internal: state = IDLE, wr_ptr = 0, rd_ptr = 0.
  - Buffer contents are not reset.
- **Reset mid-frame:** `valid` drops asynchronously. The partial frame is abandoned with no eop.
- **Latency:**
  - `start` accepted in cycle N → first beat (`valid`, `sop`) in cycle N+1.
  - With `ready` held high, a frame of W words occupies cycles N+1..N+W.
  - `done` is high at N+W+1 and `busy` is low from N+W+2.
  - The next `start` can be accepted at N+W+2. Minimum frame-to-frame gap is 2 idle cycles.
- **Registered outputs:** `busy`, `done`, `len_err` and `frames_sent` are registered. Avalon-ST outputs decode from state and rd_ptr with no added delay.
- **Buffer read:** combinational (register array), so `data_out` is valid in the same cycle rd_ptr changes.

## Test plan
- **Basic frame:**
  - Stimulus: load 16 words 0x00010203, 0x04050607, …; `byte_len` = 64; `start`; `ready` held high.
  - Response: 16 beats in consecutive cycles; `sop` on beat 0 only; `eop` on beat 15 with `empty` = 0; `done` one cycle later; `frames_sent` = 1.
- **Odd length:**
  - Stimulus: `byte_len` = 61.
  - Response: 16 beats, `eop` on beat 15 with `empty` = 3. `byte_len` = 1 gives a single beat with `sop` = `eop` = 1 and `empty` = 3.
- **Backpressure:**
  - Stimulus: `ready` toggles 1,0,0,1,… during a 10-word frame.
  - Response: beats advance only when `ready` = 1; `data_out`/`sop`/`eop` stay constant while `ready` = 0; all 10 words arrive in order with no duplicates.
- **Illegal and busy starts:**
  - Stimulus: `byte_len` = 0, then 257 with DEPTH = 64, then a `start` pulse mid-frame.
  - Response: no `valid` for the two illegal starts and `len_err` = 1; the mid-frame `start` has no effect; the next legal start clears `len_err`.
- **Load limits:**
  - Stimulus: 70 `load_en` writes with DEPTH = 64, then `load_clear` and `load_en` in the same cycle, then a retransmit.
  - Response: writes 65–70 are dropped; after the clear/write cycle wr_ptr = 0 and the word is not written; retransmitting the same buffer twice gives identical beats and `frames_sent` = 2.
- **Reset mid-frame:**
  - Stimulus: assert `n_rst` low during beat 5 of a frame.
  - Response: `valid`/`busy` go low immediately and `frames_sent` = 0; after release, a fresh `start` sends the complete frame from `sop`.
